// File: rtl/elevator_pkg.sv
// Shared elevator defaults and the per-floor request state type.
// Revision 1.0
`default_nettype none

package elevator_pkg;

   localparam int NUM_FLOORS_DEF      = 10;
   localparam int FLOOR_WIDTH_DEF     = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 16;

   typedef enum logic {
      REQ_IDLE    = 1'b0,
      REQ_PENDING = 1'b1
   } req_state_t;

endpackage

`default_nettype wire

// File: rtl/button_conditioner.sv
// One call button: 2-flop synchronizer, optional debounce (REQ_DEBOUNCE_EN), rising-edge pulse.
// Revision 1.0
`default_nettype none

module button_conditioner
   import elevator_pkg::*;
`ifdef REQ_DEBOUNCE_EN
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
`endif
(
   input  logic clk,
   input  logic reset_n,
   input  logic button_i,
   output logic pulse_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], button_i};
      end
   end

`ifdef REQ_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!sync_q[1]) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      stable_d = (cnt_q == CNT_MAX);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   // Fire only on the first cycle the counter sits at its saturation value.
   assign pulse_o = (cnt_q == CNT_MAX) && !stable_q;
`else
   logic level_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= 1'b0;
      end else begin
         level_q <= sync_q[1];
      end
   end

   assign pulse_o = sync_q[1] && !level_q;
`endif

endmodule

`default_nettype wire

// File: rtl/request_manager.sv
// Latches conditioned floor calls, retires/flushes them, reports above/below and count.
// Revision 1.0 -- optional debounce via REQ_DEBOUNCE_EN.
`default_nettype none

module request_manager
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
   parameter int FLOOR_WIDTH = FLOOR_WIDTH_DEF
`ifdef REQ_DEBOUNCE_EN
   ,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`endif
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_FLOORS-1:0]  call_buttons,
   input  logic                   emergency_stop,
   input  logic [FLOOR_WIDTH-1:0] current_floor,
   input  logic                   clear_current_request,
   output logic [NUM_FLOORS-1:0]  floor_requests,
   output logic                   has_request_above,
   output logic                   has_request_below,
   output logic [FLOOR_WIDTH:0]   request_count
);

   logic [NUM_FLOORS-1:0] edge_pulse;
   logic [NUM_FLOORS-1:0] clr_vec;
   req_state_t            state_q [NUM_FLOORS];
   req_state_t            state_d [NUM_FLOORS];
   logic [FLOOR_WIDTH:0]  count_q, count_d;

   for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_floor
`ifdef REQ_DEBOUNCE_EN
      button_conditioner #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cond (
`else
      button_conditioner u_cond (
`endif
         .clk      (clk),
         .reset_n  (reset_n),
         .button_i (call_buttons[g]),
         .pulse_o  (edge_pulse[g])
      );

      assign floor_requests[g] = (state_q[g] == REQ_PENDING);
   end

   // A floor out of range never matches any index, so such a clear is a no-op.
   always_comb begin
      clr_vec = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         clr_vec[i] = emergency_stop ||
                      (clear_current_request && (int'(current_floor) == i));
      end
   end

   // Clear beats a same-cycle set: the door is already open at that floor.
   always_comb begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
         state_d[i] = state_q[i];
         if (clr_vec[i]) begin
            state_d[i] = REQ_IDLE;
         end else if ((state_q[i] == REQ_IDLE) && edge_pulse[i]) begin
            state_d[i] = REQ_PENDING;
         end
      end
   end

   always_comb begin
      count_d = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         count_d = count_d + {{FLOOR_WIDTH{1'b0}}, (state_d[i] == REQ_PENDING)};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            state_q[i] <= REQ_IDLE;
         end
         count_q <= '0;
      end else begin
         for (int i = 0; i < NUM_FLOORS; i++) begin
            state_q[i] <= state_d[i];
         end
         count_q <= count_d;
      end
   end

   assign request_count = count_q;

   always_comb begin
      has_request_above = 1'b0;
      has_request_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (floor_requests[i] && (i > int'(current_floor))) begin
            has_request_above = 1'b1;
         end
         if (floor_requests[i] && (i < int'(current_floor))) begin
            has_request_below = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_request_manager.sv
// Self-checking bench for request_manager: directed scenarios plus randomized traffic vs a latency model.
`default_nettype none

module tb_request_manager;

   localparam int NF = 10;
   localparam int FW = 4;
`ifdef REQ_DEBOUNCE_EN
   localparam int DEB   = 16;
   localparam int EXTRA = DEB;
   localparam int PRESS = DEB + 4;
   localparam int TOG   = 39;
`else
   localparam int EXTRA = 0;
   localparam int PRESS = 1;
   localparam int TOG   = 7;
`endif
   localparam int SETTLE = EXTRA + 6;

   logic          clk;
   logic          reset_n;
   logic [NF-1:0] call_buttons;
   logic          emergency_stop;
   logic [FW-1:0] current_floor;
   logic          clear_current_request;
   logic [NF-1:0] floor_requests;
   logic          has_request_above;
   logic          has_request_below;
   logic [FW:0]   request_count;

   int n_checks = 0;
   int n_fail   = 0;

   request_manager dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .call_buttons          (call_buttons),
      .emergency_stop        (emergency_stop),
      .current_floor         (current_floor),
      .clear_current_request (clear_current_request),
      .floor_requests        (floor_requests),
      .has_request_above     (has_request_above),
      .has_request_below     (has_request_below),
      .request_count         (request_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a raw rise sampled at edge N takes effect at edge N+2(+DEB).
   // h0/h1/h2 hold the raw samples from 1, 2 and 3 edges ago.
   logic [NF-1:0] m_req;
   logic [NF-1:0] h0, h1, h2;
`ifdef REQ_DEBOUNCE_EN
   int m_run [NF];

   function automatic int run_next(input int i);
      if (!h2[i]) return 0;
      return (m_run[i] >= DEB) ? DEB : m_run[i] + 1;
   endfunction
`endif

   function automatic logic [NF-1:0] next_req();
      logic [NF-1:0] r;
      r = m_req;
      for (int i = 0; i < NF; i++) begin
         logic set_evt;
`ifdef REQ_DEBOUNCE_EN
         set_evt = (run_next(i) == DEB) && (m_run[i] != DEB);
`else
         set_evt = h1[i] && !h2[i];
`endif
         if (emergency_stop || (clear_current_request && int'(current_floor) == i))
            r[i] = 1'b0;
         else if (set_evt)
            r[i] = 1'b1;
      end
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_req <= '0;
         h0    <= '0;
         h1    <= '0;
         h2    <= '0;
`ifdef REQ_DEBOUNCE_EN
         for (int i = 0; i < NF; i++) m_run[i] <= 0;
`endif
      end else begin
         m_req <= next_req();
         h0    <= call_buttons;
         h1    <= h0;
         h2    <= h1;
`ifdef REQ_DEBOUNCE_EN
         for (int i = 0; i < NF; i++) m_run[i] <= run_next(i);
`endif
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      logic exp_above, exp_below;
      exp_above = 1'b0;
      exp_below = 1'b0;
      for (int i = 0; i < NF; i++) begin
         if (m_req[i] && i > int'(current_floor)) exp_above = 1'b1;
         if (m_req[i] && i < int'(current_floor)) exp_below = 1'b1;
      end
      check("model_req",   32'(floor_requests),   32'(m_req));
      check("model_count", 32'(request_count),    32'($countones(m_req)));
      check("model_above", 32'(has_request_above), 32'(exp_above));
      check("model_below", 32'(has_request_below), 32'(exp_below));
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n               = 1'b0;
      call_buttons          = '0;
      emergency_stop        = 1'b0;
      current_floor         = 4'd5;
      clear_current_request = 1'b0;
      cycles(3);
      check("reset_req",   32'(floor_requests),    32'h0);
      check("reset_count", 32'(request_count),     32'h0);
      check("reset_above", 32'(has_request_above), 32'h0);
      check("reset_below", 32'(has_request_below), 32'h0);
      current_floor = 4'd0;
      reset_n       = 1'b1;
      cycles(2);

      // Single press on floor 3
      call_buttons[3] = 1'b1; cycles(PRESS); call_buttons[3] = 1'b0; cycles(SETTLE);
      check("t1_req",   32'(floor_requests),    32'h008);
      check("t1_above", 32'(has_request_above), 32'h1);
      check("t1_below", 32'(has_request_below), 32'h0);
      check("t1_count", 32'(request_count),     32'h1);

      // Long hold, then a re-press while pending
      call_buttons[5] = 1'b1; cycles(20); call_buttons[5] = 1'b0; cycles(SETTLE);
      check("t2_req",   32'(floor_requests), 32'h028);
      check("t2_count", 32'(request_count),  32'h2);
      call_buttons[5] = 1'b1; cycles(PRESS); call_buttons[5] = 1'b0; cycles(SETTLE);
      check("t2_repress_req",   32'(floor_requests), 32'h028);
      check("t2_repress_count", 32'(request_count),  32'h2);

      emergency_stop = 1'b1; cycles(1); emergency_stop = 1'b0;
      check("flush_req", 32'(floor_requests), 32'h0);

      // Retire floor 7 while 2 stays pending
      call_buttons[2] = 1'b1; call_buttons[7] = 1'b1; cycles(PRESS);
      call_buttons[2] = 1'b0; call_buttons[7] = 1'b0; cycles(SETTLE);
      current_floor = 4'd7; clear_current_request = 1'b1; cycles(1);
      clear_current_request = 1'b0; cycles(1);
      check("t3_req",   32'(floor_requests),    32'h004);
      check("t3_below", 32'(has_request_below), 32'h1);
      check("t3_above", 32'(has_request_above), 32'h0);
      check("t3_count", 32'(request_count),     32'h1);

      // Set and clear of floor 4 land on the same edge
      current_floor = 4'd4; call_buttons[4] = 1'b1; cycles(2 + EXTRA);
      clear_current_request = 1'b1; cycles(1);
      clear_current_request = 1'b0; call_buttons[4] = 1'b0; cycles(SETTLE);
      check("t4_req", 32'(floor_requests), 32'h004);

      // Emergency stop flush with a button held through it
      call_buttons[1] = 1'b1; call_buttons[6] = 1'b1; call_buttons[9] = 1'b1; cycles(PRESS);
      call_buttons = '0; cycles(SETTLE);
      check("t5_req",   32'(floor_requests), 32'h246);
      check("t5_count", 32'(request_count),  32'h4);
      emergency_stop = 1'b1; call_buttons[2] = 1'b1; cycles(1);
      check("t5_flush_req",   32'(floor_requests), 32'h0);
      check("t5_flush_count", 32'(request_count),  32'h0);
      cycles(SETTLE); emergency_stop = 1'b0; cycles(SETTLE);
      check("t5_release_req",   32'(floor_requests), 32'h0);
      check("t5_release_count", 32'(request_count),  32'h0);
      call_buttons[2] = 1'b0; cycles(2);

      // Out-of-range floor
      call_buttons[0] = 1'b1; call_buttons[8] = 1'b1; cycles(PRESS);
      call_buttons = '0; cycles(SETTLE);
      current_floor = 4'd12; cycles(1);
      check("oor_req",   32'(floor_requests),    32'h101);
      check("oor_above", 32'(has_request_above), 32'h0);
      check("oor_below", 32'(has_request_below), 32'h1);
      clear_current_request = 1'b1; cycles(1); clear_current_request = 1'b0; cycles(1);
      check("oor_clear_req",   32'(floor_requests), 32'h101);
      check("oor_clear_count", 32'(request_count),  32'h2);
      current_floor = 4'd8; #1;
      check("at8_above", 32'(has_request_above), 32'h0);
      check("at8_below", 32'(has_request_below), 32'h1);
      current_floor = 4'd0; #1;
      check("at0_above", 32'(has_request_above), 32'h1);
      check("at0_below", 32'(has_request_below), 32'h0);

      // Reset while a press is in flight
      call_buttons[5] = 1'b1; cycles(2);
      reset_n = 1'b0; call_buttons[5] = 1'b0; cycles(1);
      check("rst_mid_req",   32'(floor_requests),    32'h0);
      check("rst_mid_count", 32'(request_count),     32'h0);
      check("rst_mid_above", 32'(has_request_above), 32'h0);
      reset_n = 1'b1; cycles(SETTLE);
      check("rst_after_req", 32'(floor_requests), 32'h0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NF; b++) begin
            if ($urandom_range(0, TOG) == 0) call_buttons[b] = ~call_buttons[b];
         end
         current_floor = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
         clear_current_request = ($urandom_range(0, 5) == 0);
         emergency_stop        = ($urandom_range(0, 39) == 0);
         reset_n               = ($urandom_range(0, 499) != 0);
         cycles(1);
      end
      reset_n = 1'b1; emergency_stop = 1'b0; clear_current_request = 1'b0;
      cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
